uart_tx: RTL

Serial transmitter that is the directly upstream peer of `uart_rx`. It accepts a parallel word over a valid/ready handshake and serialises it LSB-first on `tx` as a UART frame: a start bit, the data bits, an optional parity bit, and one or more stop bits. Its parameters match `uart_rx`, so `tx` can drive the receiver's `rx` pin directly in loopback, or drive an external link.

---
 rtl/uart_tx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART serialiser. Accepts a parallel word over valid/ready and
// sends start bit, LSB-first data, optional parity, then STOP_BIT stop bits.
// Every output is driven straight from a register, so tx is glitch-free.
module uart_tx #(
   parameter int BAUD_DIV    = 434,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_TYPE = 1,
   parameter int STOP_BIT    = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] data_in,
   input  logic                 valid,
   output logic                 ready,
   output logic                 done,
   output logic                 tx
);

   localparam int BAUD_W = (BAUD_DIV  > 1) ? $clog2(BAUD_DIV)  : 1;
   localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int STOP_W = (STOP_BIT  > 1) ? $clog2(STOP_BIT)  : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BIT - 1);

   // Parity types other than even (1) and odd (2) send no parity bit.
   localparam logic PARITY_EN  = (PARITY_TYPE == 1) || (PARITY_TYPE == 2);
   localparam logic PARITY_ODD = (PARITY_TYPE == 2);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                 state_reg,    state_next;
   logic [BAUD_W-1:0]      baud_cnt_reg, baud_cnt_next;
   logic [BIT_W-1:0]       bit_cnt_reg,  bit_cnt_next;
   logic [STOP_W-1:0]      stop_cnt_reg, stop_cnt_next;
   logic [DATA_BITS-1:0]   shift_reg,    shift_next;
   logic                   parity_reg,   parity_next;
   logic                   tx_reg,       tx_next;
   logic                   ready_reg,    ready_next;
   logic                   done_reg,     done_next;
   logic                   bit_tick;

   assign tx    = tx_reg;
   assign ready = ready_reg;
   assign done  = done_reg;

   // A bit boundary is the edge on which the baud counter sits at its last value.
   assign bit_tick = (baud_cnt_reg == BAUD_LAST);

   // State and datapath registers; reset forces the idle line immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         baud_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         stop_cnt_reg <= '0;
         shift_reg    <= '0;
         parity_reg   <= 1'b0;
         tx_reg       <= 1'b1;
         ready_reg    <= 1'b1;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         stop_cnt_reg <= stop_cnt_next;
         shift_reg    <= shift_next;
         parity_reg   <= parity_next;
         tx_reg       <= tx_next;
         ready_reg    <= ready_next;
         done_reg     <= done_next;
      end
   end

   // Next-state logic: the line value for each bit is decided at the boundary
   // that starts it, so tx changes exactly on bit boundaries.
   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = bit_tick ? '0 : baud_cnt_reg + BAUD_W'(1);
      bit_cnt_next  = bit_cnt_reg;
      stop_cnt_next = stop_cnt_reg;
      shift_next    = shift_reg;
      parity_next   = parity_reg;
      tx_next       = tx_reg;
      ready_next    = ready_reg;
      done_next     = 1'b0;

      case (state_reg)
         IDLE: begin
            baud_cnt_next = '0;
            bit_cnt_next  = '0;
            stop_cnt_next = '0;
            tx_next       = 1'b1;
            ready_next    = 1'b1;
            if (valid && ready_reg) begin
               state_next  = START;
               tx_next     = 1'b0;
               ready_next  = 1'b0;
               shift_next  = data_in;
               parity_next = PARITY_ODD ? ~^data_in : ^data_in;
            end
         end

         START: begin
            if (bit_tick) begin
               state_next = DATA;
               tx_next    = shift_reg[0];
            end
         end

         DATA: begin
            if (bit_tick) begin
               if (bit_cnt_reg == BIT_LAST) begin
                  bit_cnt_next = '0;
                  if (PARITY_EN) begin
                     state_next = PARITY;
                     tx_next    = parity_reg;
                  end else begin
                     state_next = STOP;
                     tx_next    = 1'b1;
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                  shift_next   = shift_reg >> 1;
                  tx_next      = shift_next[0];
               end
            end
         end

         PARITY: begin
            if (bit_tick) begin
               state_next = STOP;
               tx_next    = 1'b1;
            end
         end

         STOP: begin
            tx_next = 1'b1;
            if (bit_tick) begin
               if (stop_cnt_reg == STOP_LAST) begin
                  state_next    = IDLE;
                  stop_cnt_next = '0;
                  ready_next    = 1'b1;
                  done_next     = 1'b1;
               end else begin
                  stop_cnt_next = stop_cnt_reg + STOP_W'(1);
               end
            end
         end

         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
            ready_next = 1'b1;
         end
      endcase
   end

endmodule
